// File: rtl/qproc_outport_pkg.sv
// Shared definitions for the QICK processor output-port register bank.
package qproc_outport_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      FULL = 2'd2
   } outport_st_t;

   // Width of the port index bus; never narrower than one bit.
   function automatic int port_w(input int qty);
      return (qty > 1) ? $clog2(qty) : 1;
   endfunction

endpackage

// File: rtl/qproc_outport_ch.sv
// One output-port channel: holds the current word on a valid/ready stream,
// optionally absorbs one extra word in a skid register, and records dropped
// writes in a sticky overflow flag.
// Build option: QPROC_OUTPORT_SKID_EN adds the skid register and FULL state.
module qproc_outport_ch
   import qproc_outport_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tready,
   output logic              tvalid,
   output logic [DATA_W-1:0] tdata,
   output logic              busy,
   output logic              ovf
);

   outport_st_t       state_q, state_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              tvalid_q, tvalid_d;
   logic              ovf_q, ovf_d;
   logic              drop;
   logic              hs;
`ifdef QPROC_OUTPORT_SKID_EN
   logic [DATA_W-1:0] skid_q, skid_d;
`endif

   assign hs = tvalid_q & tready;

   // Next-state, data movement and drop detection for this port.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      drop    = 1'b0;
`ifdef QPROC_OUTPORT_SKID_EN
      skid_d  = skid_q;
`endif
      case (state_q)
         IDLE: begin
            if (wr_en) begin
               out_d   = wr_data;
               state_d = PEND;
            end
         end
         PEND: begin
            if (hs) begin
               if (wr_en) begin
                  out_d = wr_data;
               end else begin
                  state_d = IDLE;
               end
            end else if (wr_en) begin
`ifdef QPROC_OUTPORT_SKID_EN
               skid_d  = wr_data;
               state_d = FULL;
`else
               drop    = 1'b1;
`endif
            end
         end
`ifdef QPROC_OUTPORT_SKID_EN
         FULL: begin
            if (hs) begin
               out_d = skid_q;
               if (wr_en) begin
                  skid_d = wr_data;
               end else begin
                  state_d = PEND;
               end
            end else if (wr_en) begin
               drop = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
      tvalid_d = (state_d != IDLE);
      ovf_d    = (ovf_q & ~clear) | drop;
   end

   // Port state, output word and sticky flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         out_q    <= '0;
         tvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef QPROC_OUTPORT_SKID_EN
         skid_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         tvalid_q <= tvalid_d;
         ovf_q    <= ovf_d;
`ifdef QPROC_OUTPORT_SKID_EN
         skid_q   <= skid_d;
`endif
      end
   end

   assign tvalid = tvalid_q;
   assign tdata  = out_q;
   assign ovf    = ovf_q;
`ifdef QPROC_OUTPORT_SKID_EN
   assign busy   = (state_q == FULL);
`else
   assign busy   = (state_q == PEND);
`endif

endmodule

// File: rtl/qproc_outport_reg.sv
// Output-port register bank: decodes single-cycle processor writes onto
// PORT_QTY independent valid/ready output channels and flags writes to
// non-existent ports.
// Build option: QPROC_OUTPORT_SKID_EN gives every channel a one-deep skid.
module qproc_outport_reg
   import qproc_outport_pkg::*;
#(
   parameter  int PORT_QTY = 2,
   localparam int PW       = port_w(PORT_QTY)
)(
   input  logic                             c_clk_i,
   input  logic                             c_rst_ni,
   input  logic                             c_clear,
   input  logic                             wr_en_i,
   input  logic [PW-1:0]                    wr_port_i,
   input  logic [DATA_W-1:0]                wr_data_i,
   input  logic [PORT_QTY-1:0]              port_tready_i,
   output logic [PORT_QTY-1:0]              port_tvalid_o,
   output logic [PORT_QTY-1:0][DATA_W-1:0]  port_tdata_o,
   output logic [PORT_QTY-1:0]              port_busy_o,
   output logic [PORT_QTY-1:0]              port_ovf_o,
   output logic                             addr_err_o
);

   int unsigned         port_idx;
   logic                in_range;
   logic [PORT_QTY-1:0] ch_wr;
   logic                addr_err_q, addr_err_d;

   // Range check of the write index and sticky address-error update.
   always_comb begin
      port_idx   = 32'(wr_port_i);
      in_range   = (port_idx < 32'(PORT_QTY));
      addr_err_d = (addr_err_q & ~c_clear) | (wr_en_i & ~in_range);
   end

   // Address-error flag register.
   always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err_o = addr_err_q;

   for (genvar i = 0; i < PORT_QTY; i++) begin : g_ch
      assign ch_wr[i] = wr_en_i & in_range & (wr_port_i == PW'(i));

      qproc_outport_ch u_ch (
         .clk     (c_clk_i),
         .rst_n   (c_rst_ni),
         .clear   (c_clear),
         .wr_en   (ch_wr[i]),
         .wr_data (wr_data_i),
         .tready  (port_tready_i[i]),
         .tvalid  (port_tvalid_o[i]),
         .tdata   (port_tdata_o[i]),
         .busy    (port_busy_o[i]),
         .ovf     (port_ovf_o[i])
      );
   end

endmodule

// File: tb/tb_qproc_outport_reg.sv
// Self-checking bench for qproc_outport_reg with three ports. A queue-style
// reference model (per-port FIFO of pending words, depth 1 or 2) predicts
// every output each cycle; directed steps add literal expectations.
// Honours QPROC_OUTPORT_SKID_EN in the same way as the design.
module tb_qproc_outport_reg;
   import qproc_outport_pkg::*;

   localparam int NP = 3;
`ifdef QPROC_OUTPORT_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic                        c_clk_i = 1'b0;
   logic                        c_rst_ni = 1'b0;
   logic                        c_clear = 1'b0;
   logic                        wr_en_i = 1'b0;
   logic [1:0]                  wr_port_i = '0;
   logic [DATA_W-1:0]           wr_data_i = '0;
   logic [NP-1:0]               port_tready_i = '0;
   logic [NP-1:0]               port_tvalid_o;
   logic [NP-1:0][DATA_W-1:0]   port_tdata_o;
   logic [NP-1:0]               port_busy_o;
   logic [NP-1:0]               port_ovf_o;
   logic                        addr_err_o;

   int total = 0;
   int bad = 0;
   logic check_en = 1'b0;

   // Reference model state: pending words per port, last presented word,
   // sticky flags.
   logic [DATA_W-1:0] m_fifo [NP][2];
   int                m_cnt  [NP];
   logic [DATA_W-1:0] m_held [NP];
   logic [NP-1:0]     m_ovf;
   logic              m_err;

   qproc_outport_reg #(.PORT_QTY(NP)) dut (
      .c_clk_i       (c_clk_i),
      .c_rst_ni      (c_rst_ni),
      .c_clear       (c_clear),
      .wr_en_i       (wr_en_i),
      .wr_port_i     (wr_port_i),
      .wr_data_i     (wr_data_i),
      .port_tready_i (port_tready_i),
      .port_tvalid_o (port_tvalid_o),
      .port_tdata_o  (port_tdata_o),
      .port_busy_o   (port_busy_o),
      .port_ovf_o    (port_ovf_o),
      .addr_err_o    (addr_err_o)
   );

   always #5 c_clk_i = ~c_clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int p = 0; p < NP; p++) begin
         m_cnt[p]     = 0;
         m_held[p]    = '0;
         m_fifo[p][0] = '0;
         m_fifo[p][1] = '0;
      end
      m_ovf = '0;
      m_err = 1'b0;
   endtask

   // One clock of the specification's rules: accepted words leave the head,
   // a write joins the tail if there is room, otherwise it is dropped.
   task automatic modelStep();
      logic [NP-1:0] ovf_set;
      logic          err_set;
      int            wp;
      ovf_set = '0;
      err_set = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (m_cnt[p] > 0 && port_tready_i[p]) begin
            m_fifo[p][0] = m_fifo[p][1];
            m_cnt[p]--;
         end
      end
      wp = int'(wr_port_i);
      if (wr_en_i) begin
         if (wp >= NP) begin
            err_set = 1'b1;
         end else if (m_cnt[wp] < CAP) begin
            m_fifo[wp][m_cnt[wp]] = wr_data_i;
            m_cnt[wp]++;
         end else begin
            ovf_set[wp] = 1'b1;
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (m_cnt[p] > 0) m_held[p] = m_fifo[p][0];
      end
      m_ovf = (m_ovf & ~{NP{c_clear}}) | ovf_set;
      m_err = (m_err & ~c_clear) | err_set;
   endtask

   // Model advances on the same edges as the design, including async reset.
   always @(posedge c_clk_i or negedge c_rst_ni) begin
      if (!c_rst_ni) modelReset();
      else           modelStep();
   end

   // Compare every output against the model midway through each cycle.
   always @(negedge c_clk_i) begin
      if (check_en) begin
         for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("tvalid%0d", p), 64'(port_tvalid_o[p]), 64'(m_cnt[p] != 0));
            checkOutput($sformatf("tdata%0d", p), port_tdata_o[p], m_held[p]);
            checkOutput($sformatf("busy%0d", p), 64'(port_busy_o[p]), 64'(m_cnt[p] == CAP));
            checkOutput($sformatf("ovf%0d", p), 64'(port_ovf_o[p]), 64'(m_ovf[p]));
         end
         checkOutput("addr_err", 64'(addr_err_o), 64'(m_err));
      end
   end

   // Drive one cycle of inputs from a negedge and advance to the next negedge.
   task automatic applyStimulus(input logic we, input logic [1:0] port, input logic [63:0] data,
                                input logic [NP-1:0] rdy, input logic clr);
      wr_en_i       = we;
      wr_port_i     = port;
      wr_data_i     = data;
      port_tready_i = rdy;
      c_clear       = clr;
      @(negedge c_clk_i);
   endtask

   initial begin
      modelReset();
      repeat (2) @(negedge c_clk_i);
      c_rst_ni = 1'b1;
      check_en = 1'b1;
      checkOutput("rst_tvalid", 64'(port_tvalid_o), 64'h0);
      checkOutput("rst_busy", 64'(port_busy_o), 64'h0);
      checkOutput("rst_addr_err", 64'(addr_err_o), 64'h0);

      // Single word with downstream ready: valid for exactly one cycle.
      applyStimulus(1'b1, 2'd0, 64'h1122334455667788, 3'b001, 1'b0);
      checkOutput("w1_tvalid", 64'(port_tvalid_o[0]), 64'h1);
      checkOutput("w1_tdata", port_tdata_o[0], 64'h1122334455667788);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      checkOutput("w1_tvalid_gone", 64'(port_tvalid_o[0]), 64'h0);
      checkOutput("w1_ovf", 64'(port_ovf_o[0]), 64'h0);

      // Two writes into a stalled port.
      applyStimulus(1'b1, 2'd0, 64'hA, 3'b000, 1'b0);
      checkOutput("stall_a", port_tdata_o[0], 64'hA);
      applyStimulus(1'b1, 2'd0, 64'hB, 3'b000, 1'b0);
      checkOutput("stall_hold", port_tdata_o[0], 64'hA);
`ifdef QPROC_OUTPORT_SKID_EN
      checkOutput("stall_ovf_skid", 64'(port_ovf_o[0]), 64'h0);
      checkOutput("stall_busy_skid", 64'(port_busy_o[0]), 64'h1);
      applyStimulus(1'b1, 2'd0, 64'hE, 3'b000, 1'b0);
      checkOutput("third_ovf", 64'(port_ovf_o[0]), 64'h1);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      checkOutput("skid_drain_b", port_tdata_o[0], 64'hB);
      checkOutput("skid_drain_valid", 64'(port_tvalid_o[0]), 64'h1);
`else
      checkOutput("stall_ovf", 64'(port_ovf_o[0]), 64'h1);
      checkOutput("stall_busy", 64'(port_busy_o[0]), 64'h1);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      checkOutput("drain_idle", 64'(port_tvalid_o[0]), 64'h0);
`endif
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b000, 1'b1);
      checkOutput("clear_ovf", 64'(port_ovf_o[0]), 64'h0);

      // Handshake and a new write in the same cycle stream back to back.
      applyStimulus(1'b1, 2'd0, 64'hC, 3'b001, 1'b0);
      checkOutput("b2b_c", port_tdata_o[0], 64'hC);
      applyStimulus(1'b1, 2'd0, 64'hD, 3'b001, 1'b0);
      checkOutput("b2b_d", port_tdata_o[0], 64'hD);
      checkOutput("b2b_d_valid", 64'(port_tvalid_o[0]), 64'h1);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      checkOutput("b2b_idle", 64'(port_tvalid_o[0]), 64'h0);
      checkOutput("b2b_ovf", 64'(port_ovf_o[0]), 64'h0);

      // Write to a port that does not exist.
      applyStimulus(1'b1, 2'd3, 64'h55, 3'b000, 1'b0);
      checkOutput("addr_err_set", 64'(addr_err_o), 64'h1);
      checkOutput("addr_err_novalid", 64'(port_tvalid_o), 64'h0);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b000, 1'b1);
      checkOutput("addr_err_clr", 64'(addr_err_o), 64'h0);

      // A drop in the same cycle as clear leaves the flag set.
      applyStimulus(1'b1, 2'd0, 64'h1, 3'b000, 1'b0);
      applyStimulus(1'b1, 2'd0, 64'h2, 3'b000, 1'b0);
      applyStimulus(1'b1, 2'd0, 64'h3, 3'b000, 1'b1);
      checkOutput("set_wins", 64'(port_ovf_o[0]), 64'h1);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b0);
      applyStimulus(1'b0, 2'd0, 64'h0, 3'b001, 1'b1);

      // Asynchronous reset while port 1 holds a word.
      applyStimulus(1'b1, 2'd1, 64'h77, 3'b000, 1'b0);
      checkOutput("p1_pend", 64'(port_tvalid_o[1]), 64'h1);
      wr_en_i = 1'b0;
      #2 c_rst_ni = 1'b0;
      #1;
      checkOutput("async_tvalid1", 64'(port_tvalid_o[1]), 64'h0);
      checkOutput("async_busy", 64'(port_busy_o), 64'h0);
      @(negedge c_clk_i);
      c_rst_ni = 1'b1;
      @(negedge c_clk_i);
      checkOutput("post_rst_tvalid1", 64'(port_tvalid_o[1]), 64'h0);
      checkOutput("post_rst_busy1", 64'(port_busy_o[1]), 64'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                       {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 15) == 0));
      end

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
